fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Combines the program counter (PC) register with the IF/ID pipeline register of the 5-stage MIPS32 pipeline.
- Drives the instruction-memory fetch address.
- Consumes the hazard unit's stall and the interrupt request, plus the ID-stage redirect signals: branch/jump, eret.
- Produces the decode-stage instruction word, PC, link address (PC+8), fetch exception code and branch-delay flag.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, first valid instruction address.
- IM_DEPTH, 1024, number of 32-bit instruction-memory words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; freezes PC and IF/ID
- IntReq  in  1  interrupt/exception request from CP0
- eret_D  in  1  eret is in decode
- EPC  in  32  return address from CP0
- jump_taken_D  in  1  decode-stage branch taken or jump
- jump_target_D  in  32  resolved target for jump_taken_D
- is_branch_D  in  1  decode instruction is any branch/jump class
- Instr_F  in  32  instruction word read from IM at PC_F
- PC_F  out  32  current fetch address (registered)
- InstrD  out  32  decode-stage instruction
- PC_D  out  32  decode-stage PC
- PC8_D  out  32  PC_D + 8 (link value)
- ExcCode_D  out  5  fetch exception code (0 none, 4 AdEL)
- BD_D  out  1  InstrD sits in a branch delay slot

Behaviour:
- All state updates on the rising edge of clk. No combinational path from any input to any output; all outputs are registered.
- Reset (sync, active-high, highest priority):
  - PC_F = RESET_PC
  - InstrD = 0
  - PC_D = RESET_PC
  - PC8_D = RESET_PC+8
  - ExcCode_D = 0
  - BD_D = 0
- Fetch fault, combinational on PC_F. The fetch is faulty if any of:
  - PC_F[1:0] != 0
  - PC_F < IM_BASE
  - PC_F >= IM_BASE + 4*IM_DEPTH

  Compare unsigned in 33 bits so the bound does not wrap.
- Next-state priority, evaluated per cycle, highest first:
  1. IntReq:
     - PC_F <= HANDLER_PC
     - IF/ID flushed: InstrD <= 0, ExcCode_D <= 0, BD_D <= 0, PC_D <= PC_F, PC8_D <= PC_F+8
     - stall is ignored even if asserted
  2. stall:
     - PC_F and every IF/ID output hold their value
     - eret_D and jump_taken_D are ignored this cycle
  3. eret_D:
     - PC_F <= EPC
     - IF/ID flushed as in case 1 (eret has no delay slot)
  4. jump_taken_D:
     - PC_F <= jump_target_D
     - IF/ID loads normally; the fetched word is the delay slot
  5. Otherwise:
     - PC_F <= PC_F + 4 (mod 2^32)
     - IF/ID loads normally
- Normal IF/ID load:
  - PC_D <= PC_F
  - PC8_D <= PC_F + 8
  - BD_D <= is_branch_D, set for not-taken branches too
  - If fault: InstrD <= 0 and ExcCode_D <= 4
  - Else: InstrD <= Instr_F and ExcCode_D <= 0
- A misaligned EPC or jump_target_D is loaded into PC_F unchanged. The fault is reported on the following IF/ID load, not at redirect time.
- Stall persisting N cycles holds exactly; release resumes with the held PC (no skipped or duplicated fetch).
- PC_F = 32'hFFFF_FFFC sequential wraps to 0 and then faults (below IM_BASE).
- Reset asserted mid-stall or mid-redirect overrides everything in that cycle.

Test Plan:
- Reset, then 3 free cycles with Instr_F = 0x24080001 → PC_F 0x3000, 0x3004, 0x3008, 0x300C. At the third edge: InstrD = 0x24080001, PC_D = 0x3008, PC8_D = 0x3010, ExcCode_D = 0.
- At PC_F = 0x3010, assert stall for 2 cycles → PC_F stays 0x3010 and IF/ID is unchanged for 2 edges. After release the next edge gives PC_D = 0x3010 and PC_F = 0x3014.
- At PC_F = 0x3020, pulse jump_taken_D = 1, is_branch_D = 1, jump_target_D = 0x3100 → PC_F = 0x3100, PC_D = 0x3020, BD_D = 1. The next edge gives PC_D = 0x3100 and BD_D = 0.
- Assert IntReq and stall together at PC_F = 0x3040 → PC_F = 0x4180, InstrD = 0, BD_D = 0, PC_D = 0x3040.
- Pulse eret_D with EPC = 0x3042 → PC_F = 0x3042 and IF/ID flushed. The next edge gives InstrD = 0 and ExcCode_D = 4. Also jump to 0x2FFC gives ExcCode_D = 4 one edge after the redirect.
- Assert reset while stall = 1 at PC_F = 0x3050 → PC_F = 0x3000 and all IF/ID outputs at their reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: program counter plus IF/ID pipeline register of a 5-stage MIPS32
// pipeline. Selects the next fetch address (interrupt, stall, eret, jump,
// sequential) and captures the fetched word into the decode-stage register.
// Fetch-address faults are flagged as AdEL on the IF/ID load that consumes them.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int          IM_DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        IntReq,
    input  logic        eret_D,
    input  logic [31:0] EPC,
    input  logic        jump_taken_D,
    input  logic [31:0] jump_target_D,
    input  logic        is_branch_D,
    input  logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] InstrD,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic [4:0]  ExcCode_D,
    output logic        BD_D
);

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    // Bounds are held in 33 bits so IM_BASE + 4*IM_DEPTH cannot wrap to zero.
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc8_d;
    logic [4:0]  r_exc_d;
    logic        r_bd_d;

    logic [31:0] r_pc_f_next;
    logic [31:0] r_instr_d_next;
    logic [31:0] r_pc_d_next;
    logic [31:0] r_pc8_d_next;
    logic [4:0]  r_exc_d_next;
    logic        r_bd_d_next;

    logic [32:0] w_pc_ext;
    logic        w_fetch_fault;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;

    assign w_pc_ext      = {1'b0, r_pc_f};
    assign w_fetch_fault = (r_pc_f[1:0] != 2'b00) || (w_pc_ext < IM_LO) || (w_pc_ext >= IM_HI);
    assign w_pc_plus4    = r_pc_f + 32'd4;
    assign w_pc_plus8    = r_pc_f + 32'd8;

    // Next-state selection: interrupt > stall > eret > jump > sequential.
    always_comb begin
        r_pc_f_next    = r_pc_f;
        r_instr_d_next = r_instr_d;
        r_pc_d_next    = r_pc_d;
        r_pc8_d_next   = r_pc8_d;
        r_exc_d_next   = r_exc_d;
        r_bd_d_next    = r_bd_d;
        if (IntReq || (!stall && eret_D)) begin
            // Redirect with flush: the word in flight is discarded, no delay slot.
            r_pc_f_next    = IntReq ? HANDLER_PC : EPC;
            r_instr_d_next = 32'd0;
            r_exc_d_next   = EXC_NONE;
            r_bd_d_next    = 1'b0;
            r_pc_d_next    = r_pc_f;
            r_pc8_d_next   = w_pc_plus8;
        end else if (!stall) begin
            // Normal load; on a taken jump the fetched word is the delay slot.
            r_pc_f_next    = jump_taken_D ? jump_target_D : w_pc_plus4;
            r_pc_d_next    = r_pc_f;
            r_pc8_d_next   = w_pc_plus8;
            r_bd_d_next    = is_branch_D;
            r_instr_d_next = w_fetch_fault ? 32'd0 : Instr_F;
            r_exc_d_next   = w_fetch_fault ? EXC_ADEL : EXC_NONE;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f    <= RESET_PC;
            r_instr_d <= 32'd0;
            r_pc_d    <= RESET_PC;
            r_pc8_d   <= RESET_PC + 32'd8;
            r_exc_d   <= EXC_NONE;
            r_bd_d    <= 1'b0;
        end else begin
            r_pc_f    <= r_pc_f_next;
            r_instr_d <= r_instr_d_next;
            r_pc_d    <= r_pc_d_next;
            r_pc8_d   <= r_pc8_d_next;
            r_exc_d   <= r_exc_d_next;
            r_bd_d    <= r_bd_d_next;
        end
    end

    assign PC_F      = r_pc_f;
    assign InstrD    = r_instr_d;
    assign PC_D      = r_pc_d;
    assign PC8_D     = r_pc8_d;
    assign ExcCode_D = r_exc_d;
    assign BD_D      = r_bd_d;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with hand-computed expected register
// contents after each clock edge; a monitor process pops and compares them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        IntReq = 1'b0;
    logic        eret_D = 1'b0;
    logic [31:0] EPC = 32'd0;
    logic        jump_taken_D = 1'b0;
    logic [31:0] jump_target_D = 32'd0;
    logic        is_branch_D = 1'b0;
    logic [31:0] Instr_F = 32'd0;
    logic [31:0] PC_F;
    logic [31:0] InstrD;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic [4:0]  ExcCode_D;
    logic        BD_D;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] instr;
        logic [31:0] pc_d;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    localparam logic [31:0] NOP_I = 32'h2408_0001;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .IntReq        (IntReq),
        .eret_D        (eret_D),
        .EPC           (EPC),
        .jump_taken_D  (jump_taken_D),
        .jump_target_D (jump_target_D),
        .is_branch_D   (is_branch_D),
        .Instr_F       (Instr_F),
        .PC_F          (PC_F),
        .InstrD        (InstrD),
        .PC_D          (PC_D),
        .PC8_D         (PC8_D),
        .ExcCode_D     (ExcCode_D),
        .BD_D          (BD_D)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue the state
    // expected right after the following rising edge.
    task automatic step(input logic rst, input logic stl, input logic irq,
                        input logic er, input logic [31:0] epc,
                        input logic jt, input logic [31:0] jtgt, input logic br,
                        input logic [31:0] instr,
                        input logic [31:0] e_pc_f, input logic [31:0] e_instr,
                        input logic [31:0] e_pc_d, input logic [4:0] e_exc,
                        input logic e_bd);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = stl; IntReq = irq; eret_D = er; EPC = epc;
        jump_taken_D = jt; jump_target_D = jtgt; is_branch_D = br; Instr_F = instr;
        e.pc_f = e_pc_f; e.instr = e_instr; e.pc_d = e_pc_d;
        e.pc8 = e_pc_d + 32'd8; e.exc = e_exc; e.bd = e_bd;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                n_txn++;
                if (PC_F !== e.pc_f || InstrD !== e.instr || PC_D !== e.pc_d ||
                    PC8_D !== e.pc8 || ExcCode_D !== e.exc || BD_D !== e.bd) begin
                    n_errors++;
                    $display("FAIL txn%0d: got pc_f=%h instr=%h pc_d=%h pc8=%h exc=%0d bd=%b, expected pc_f=%h instr=%h pc_d=%h pc8=%h exc=%0d bd=%b",
                             n_txn, PC_F, InstrD, PC_D, PC8_D, ExcCode_D, BD_D,
                             e.pc_f, e.instr, e.pc_d, e.pc8, e.exc, e.bd);
                end else begin
                    $display("txn%0d ok: pc_f=%h instr=%h pc_d=%h pc8=%h exc=%0d bd=%b",
                             n_txn, PC_F, InstrD, PC_D, PC8_D, ExcCode_D, BD_D);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //    rst stl irq er  epc           jt  jtgt          br  instr          pc_f          instr         pc_d          exc br
        step(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3000, 32'h0,        32'h0000_3000, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3004, NOP_I,        32'h0000_3000, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3008, NOP_I,        32'h0000_3004, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_300C, NOP_I,        32'h0000_3008, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3010, NOP_I,        32'h0000_300C, 0, 0);
        // two-cycle stall: everything holds even though Instr_F changes
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'hDEAD_BEEF, 32'h0000_3010, NOP_I,        32'h0000_300C, 0, 0);
        step(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'hDEAD_BEEF, 32'h0000_3010, NOP_I,        32'h0000_300C, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h1111_1111, 32'h0000_3014, 32'h1111_1111, 32'h0000_3010, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3018, NOP_I,        32'h0000_3014, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_301C, NOP_I,        32'h0000_3018, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3020, NOP_I,        32'h0000_301C, 0, 0);
        // taken jump: delay slot loads with BD set
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3100, 1, 32'hAAAA_0000, 32'h0000_3100, 32'hAAAA_0000, 32'h0000_3020, 0, 1);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3104, NOP_I,        32'h0000_3100, 0, 0);
        // not-taken branch still marks BD
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, NOP_I,         32'h0000_3108, NOP_I,        32'h0000_3104, 0, 1);
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3040, 1, NOP_I,         32'h0000_3040, NOP_I,        32'h0000_3108, 0, 1);
        // interrupt wins over stall and flushes
        step(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h5555_5555, 32'h0000_4180, 32'h0,        32'h0000_3040, 0, 0);
        // handler address lies past the IM window -> AdEL on next load
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_4184, 32'h0,        32'h0000_4180, 4, 0);
        // eret beats a simultaneous jump, flushes, loads misaligned EPC
        step(0, 0, 0, 1, 32'h0000_3042, 1, 32'h0000_3200, 1, NOP_I,         32'h0000_3042, 32'h0,        32'h0000_4184, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3046, 32'h0,        32'h0000_3042, 4, 0);
        // stall masks eret and jump
        step(0, 1, 0, 1, 32'h0000_3300, 1, 32'h0000_3400, 1, NOP_I,         32'h0000_3046, 32'h0,        32'h0000_3042, 4, 0);
        // jump below IM base; fault appears one edge later
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_2FFC, 1, NOP_I,         32'h0000_2FFC, 32'h0,        32'h0000_3046, 4, 1);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3000, 32'h0,        32'h0000_2FFC, 4, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h1234_5678, 32'h0000_3004, 32'h1234_5678, 32'h0000_3000, 0, 0);
        // upper edge: 0x3FFC is the last valid word, 0x4000 faults
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3FFC, 1, NOP_I,         32'h0000_3FFC, NOP_I,        32'h0000_3004, 0, 1);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h7777_0000, 32'h0000_4000, 32'h7777_0000, 32'h0000_3FFC, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_4004, 32'h0,        32'h0000_4000, 4, 0);
        // wrap at the top of the address space
        step(0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, NOP_I,         32'hFFFF_FFFC, 32'h0,        32'h0000_4004, 4, 1);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_0000, 32'h0,        32'hFFFF_FFFC, 4, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_0004, 32'h0,        32'h0000_0000, 4, 0);
        // get back into range, then reset during stall+jump
        step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3050, 0, NOP_I,         32'h0000_3050, 32'h0,        32'h0000_0004, 4, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, NOP_I,         32'h0000_3054, NOP_I,        32'h0000_3050, 0, 1);
        step(1, 1, 0, 0, 32'h0,        1, 32'h0000_3500, 1, NOP_I,         32'h0000_3000, 32'h0,        32'h0000_3000, 0, 0);
        step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, NOP_I,         32'h0000_3004, NOP_I,        32'h0000_3000, 0, 0);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
